// File: rtl/max_pool_layer.sv
// 2x2/stride-2 signed max-pooling over a channel-major feature map held in DRAM.
// Reads one element per request, keeps a running max per window, writes one word per window.
module max_pool_layer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned IN_BASE    = 131072,
  parameter int unsigned OUT_BASE   = 163840,
  parameter int unsigned IN_H       = 10,
  parameter int unsigned IN_W       = 10,
  parameter int unsigned CH         = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  localparam int unsigned OH = IN_H / 2;
  localparam int unsigned OW = IN_W / 2;
  localparam int unsigned CW = $clog2(CH + 1);
  localparam int unsigned YW = $clog2(OH + 1);
  localparam int unsigned XW = $clog2(OW + 1);

  localparam logic [ADDR_WIDTH-1:0] IN_BASE_A  = ADDR_WIDTH'(IN_BASE);
  localparam logic [ADDR_WIDTH-1:0] OUT_BASE_A = ADDR_WIDTH'(OUT_BASE);
  localparam logic [ADDR_WIDTH-1:0] IN_PLANE   = ADDR_WIDTH'(IN_H * IN_W);
  localparam logic [ADDR_WIDTH-1:0] IN_ROW     = ADDR_WIDTH'(IN_W);
  localparam logic [ADDR_WIDTH-1:0] OUT_PLANE  = ADDR_WIDTH'(OH * OW);
  localparam logic [ADDR_WIDTH-1:0] OUT_ROW    = ADDR_WIDTH'(OW);
  localparam logic [CW-1:0]         C_LAST     = CW'(CH - 1);
  localparam logic [YW-1:0]         Y_LAST     = YW'(OH - 1);
  localparam logic [XW-1:0]         X_LAST     = XW'(OW - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           c_q, c_d;
  logic [YW-1:0]           oy_q, oy_d;
  logic [XW-1:0]           ox_q, ox_d;
  logic [1:0]              k_q, k_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic [ADDR_WIDTH-1:0]   addr_in_q, addr_in_d;
  logic [ADDR_WIDTH-1:0]   addr_out_q, addr_out_d;
  logic                    dram_en_rd_q, dram_en_rd_d;
  logic                    dram_en_wr_q, dram_en_wr_d;
  logic                    done_q, done_d;
  logic                    last_win;
  logic [ADDR_WIDTH-1:0]   rd_addr, wr_addr;

  assign last_win = (c_q == C_LAST) && (oy_q == Y_LAST) && (ox_q == X_LAST);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    k_d     = k_q;
    max_d   = max_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RD_REQ;
          c_d     = '0;
          oy_d    = '0;
          ox_d    = '0;
          k_d     = '0;
          done_d  = 1'b0;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (dram_valid) begin
          if (k_q == 2'd0 || $signed(data_in) > $signed(max_q)) max_d = data_in;
          if (k_q == 2'd3) begin
            state_d = S_WR;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR: begin
        k_d = '0;
        if (last_win) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD_REQ;
          if (ox_q == X_LAST) begin
            ox_d = '0;
            if (oy_q == Y_LAST) begin
              oy_d = '0;
              c_d  = c_q + CW'(1);
            end else begin
              oy_d = oy_q + YW'(1);
            end
          end else begin
            ox_d = ox_q + XW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so strobes line up with the state they belong to.
    rd_addr = IN_BASE_A + ADDR_WIDTH'(c_d) * IN_PLANE
            + ADDR_WIDTH'({oy_d, k_d[1]}) * IN_ROW + ADDR_WIDTH'({ox_d, k_d[0]});
    wr_addr = OUT_BASE_A + ADDR_WIDTH'(c_d) * OUT_PLANE
            + ADDR_WIDTH'(oy_d) * OUT_ROW + ADDR_WIDTH'(ox_d);

    dram_en_rd_d = (state_d == S_RD_REQ);
    dram_en_wr_d = (state_d == S_WR);
    addr_in_d    = dram_en_rd_d ? rd_addr : addr_in_q;
    addr_out_d   = dram_en_wr_d ? wr_addr : addr_out_q;
    data_out_d   = dram_en_wr_d ? max_d : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= S_IDLE;
      c_q          <= '0;
      oy_q         <= '0;
      ox_q         <= '0;
      k_q          <= '0;
      max_q        <= '0;
      data_out_q   <= '0;
      addr_in_q    <= '0;
      addr_out_q   <= '0;
      dram_en_rd_q <= 1'b0;
      dram_en_wr_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      oy_q         <= oy_d;
      ox_q         <= ox_d;
      k_q          <= k_d;
      max_q        <= max_d;
      data_out_q   <= data_out_d;
      addr_in_q    <= addr_in_d;
      addr_out_q   <= addr_out_d;
      dram_en_rd_q <= dram_en_rd_d;
      dram_en_wr_q <= dram_en_wr_d;
      done_q       <= done_d;
    end
  end

  assign data_out   = data_out_q;
  assign addr_in    = addr_in_q;
  assign addr_out   = addr_out_q;
  assign dram_en_rd = dram_en_rd_q;
  assign dram_en_wr = dram_en_wr_q;
  assign done       = done_q;

endmodule
